// File: rtl/wr_rsp_fsm.sv
// Write responder: buffers write pulses in a small FIFO and replays them,
// in arrival order, onto a ready-handshaked memory write port, one at a time.
module wr_rsp_fsm #(
    parameter int AW    = 8,
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_in,
    input  logic [AW-1:0]            wr_addr,
    input  logic [DW-1:0]            wr_data,
    input  logic                     mem_rdy,
    output logic                     mem_wr,
    output logic [AW-1:0]            mem_addr,
    output logic [DW-1:0]            mem_data,
    output logic                     wr_ack,
    output logic                     full,
    output logic                     ovf,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   cnt
);

    // state | meaning
    // IDLE  | no write on the port; start the FIFO head if one is queued
    // ISSUE | mem_wr high, waiting for mem_rdy to complete the write
    // ACK   | wr_ack pulse for the write that just completed
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_ACK   = 2'd2
    } state_t;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            mem_wr_q, mem_wr_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_data_q, mem_data_d;
    logic            wr_ack_q, wr_ack_d;
    logic            ovf_q, ovf_d;
    logic            push, pop, full_w;

    logic [AW-1:0]   fifo_addr_q [DEPTH];
    logic [DW-1:0]   fifo_data_q [DEPTH];

    assign full_w = (cnt_q == CW'(DEPTH));

    // Next-state, FIFO bookkeeping and registered output values.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        mem_wr_d   = mem_wr_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        wr_ack_d   = 1'b0;
        ovf_d      = ovf_q;
        pop        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cnt_q != '0) begin
                    mem_addr_d = fifo_addr_q[rd_ptr_q];
                    mem_data_d = fifo_data_q[rd_ptr_q];
                    mem_wr_d   = 1'b1;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mem_rdy) begin
                    pop      = 1'b1;
                    mem_wr_d = 1'b0;
                    wr_ack_d = 1'b1;
                    state_d  = S_ACK;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                mem_wr_d = 1'b0;
                state_d  = S_IDLE;
            end
        endcase

        // A full FIFO still accepts a request if the head leaves on the same edge.
        push = wr_in && (!full_w || pop);
        if (wr_in && !push) ovf_d = 1'b1;

        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Control and output registers; reset wins over everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            wr_ack_q   <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            mem_wr_q   <= mem_wr_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            wr_ack_q   <= wr_ack_d;
            ovf_q      <= ovf_d;
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_addr_q[wr_ptr_q] <= wr_addr;
            fifo_data_q[wr_ptr_q] <= wr_data;
        end
    end

    assign mem_wr   = mem_wr_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign wr_ack   = wr_ack_q;
    assign ovf      = ovf_q;
    assign full     = full_w;
    assign busy     = (state_q != S_IDLE) || (cnt_q != '0);
    assign cnt      = cnt_q;

endmodule
